// File: rtl/tcm_axis_sink_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tcm_axis_sink_fifo
// Purpose  : AXI-Stream sink FIFO with TLAST framing and a FWFT read port.
//            Define TCM_AXIS_SINK_STRB_EN to zero bytes whose TSTRB bit is 0.
// Revision : 1.0
// ============================================================================

module tcm_axis_sink_fifo #(
  parameter int C_S_AXIS_TDATA_WIDTH = 32,
  parameter int C_FIFO_DEPTH         = 16,
  localparam int AW                  = $clog2(C_FIFO_DEPTH)
) (
  input  logic                              S_AXIS_ACLK,
  input  logic                              S_AXIS_ARESETN,
  input  logic                              S_AXIS_TVALID,
  output logic                              S_AXIS_TREADY,
  input  logic [C_S_AXIS_TDATA_WIDTH-1:0]   S_AXIS_TDATA,
  input  logic [C_S_AXIS_TDATA_WIDTH/8-1:0] S_AXIS_TSTRB,
  input  logic                              S_AXIS_TLAST,
  input  logic [31:0]                       USR_tcm_control,
  input  logic                              USR_rd_en,
  output logic                              USR_rd_valid,
  output logic [C_S_AXIS_TDATA_WIDTH-1:0]   USR_rd_data,
  output logic                              USR_rd_last,
  output logic [AW:0]                       USR_level,
  output logic [AW:0]                       USR_pkt_count,
  output logic                              USR_full,
  output logic                              USR_empty,
  output logic                              USR_pkt_done
);

  localparam int DW = C_S_AXIS_TDATA_WIDTH;
  localparam int NB = C_S_AXIS_TDATA_WIDTH / 8;
  localparam logic [AW:0] LVL_FULL = (AW+1)'(C_FIFO_DEPTH);

  logic [DW:0]   mem [C_FIFO_DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic [AW:0]   level;
  logic [AW:0]   pkt_count;
  logic          pkt_done;

  logic          flush;
  logic          enable;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic          push_last;
  logic          pop_last;
  logic [DW:0]   head;
  logic [DW-1:0] wdata;
  logic          unused_ok;

  assign flush  = USR_tcm_control[0];
  assign enable = USR_tcm_control[1];
  assign full   = (level == LVL_FULL);
  assign empty  = (level == '0);

`ifdef TCM_AXIS_SINK_STRB_EN
  for (genvar i = 0; i < NB; i++) begin : g_strb
    assign wdata[8*i +: 8] = S_AXIS_TSTRB[i] ? S_AXIS_TDATA[8*i +: 8] : 8'h00;
  end
  assign unused_ok = ^USR_tcm_control[31:2];
`else
  assign wdata     = S_AXIS_TDATA;
  assign unused_ok = ^{S_AXIS_TSTRB, USR_tcm_control[31:2]};
`endif

  // Ready depends only on control, reset and the registered level, never on TVALID/rd_en.
  assign S_AXIS_TREADY = S_AXIS_ARESETN && enable && !flush && !full;

  assign push      = S_AXIS_TVALID && S_AXIS_TREADY;
  assign pop       = USR_rd_en && !empty;
  assign head      = mem[rp];
  assign push_last = push && S_AXIS_TLAST;
  assign pop_last  = pop && head[DW];

  always_ff @(posedge S_AXIS_ACLK) begin
    if (push) begin
      mem[wp] <= {S_AXIS_TLAST, wdata};
    end
  end

  always_ff @(posedge S_AXIS_ACLK) begin
    if (!S_AXIS_ARESETN) begin
      wp        <= '0;
      rp        <= '0;
      level     <= '0;
      pkt_count <= '0;
      pkt_done  <= 1'b0;
    end else begin
      pkt_done <= push_last;
      if (flush) begin
        wp        <= '0;
        rp        <= '0;
        level     <= '0;
        pkt_count <= '0;
      end else begin
        if (push) wp <= wp + 1'b1;
        if (pop)  rp <= rp + 1'b1;
        if (push && !pop)      level <= level + 1'b1;
        else if (!push && pop) level <= level - 1'b1;
        if (push_last && !pop_last)      pkt_count <= pkt_count + 1'b1;
        else if (!push_last && pop_last) pkt_count <= pkt_count - 1'b1;
      end
    end
  end

  // Head is masked while empty so stale memory never leaks out.
  assign USR_rd_valid  = !empty;
  assign USR_rd_data   = empty ? '0 : head[DW-1:0];
  assign USR_rd_last   = !empty && head[DW];
  assign USR_level     = level;
  assign USR_pkt_count = pkt_count;
  assign USR_full      = full;
  assign USR_empty     = empty;
  assign USR_pkt_done  = pkt_done;

endmodule

`default_nettype wire

// File: tb/tb_tcm_axis_sink_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_tcm_axis_sink_fifo
// Purpose  : Self-checking bench for tcm_axis_sink_fifo (queue reference model).
// Revision : 1.0
// ============================================================================

module tb_tcm_axis_sink_fifo;

  localparam int DW = 32;
  localparam int D  = 16;
  localparam int AW = $clog2(D);

  typedef struct packed {
    logic          last;
    logic [DW-1:0] data;
  } ent_t;

  logic          clk;
  logic          aresetn;
  logic          tvalid;
  logic          tready;
  logic [DW-1:0] tdata;
  logic [3:0]    tstrb;
  logic          tlast;
  logic [31:0]   ctrl;
  logic          rd_en;
  logic          rd_valid;
  logic [DW-1:0] rd_data;
  logic          rd_last;
  logic [AW:0]   level;
  logic [AW:0]   pkt_count;
  logic          full;
  logic          empty;
  logic          pkt_done;

  int   checks;
  int   errors;
  int   pd_cnt;
  bit   cmp_en;
  ent_t q[$];
  bit   exp_pd;

  tcm_axis_sink_fifo #(
    .C_S_AXIS_TDATA_WIDTH(DW),
    .C_FIFO_DEPTH(D)
  ) dut (
    .S_AXIS_ACLK(clk),
    .S_AXIS_ARESETN(aresetn),
    .S_AXIS_TVALID(tvalid),
    .S_AXIS_TREADY(tready),
    .S_AXIS_TDATA(tdata),
    .S_AXIS_TSTRB(tstrb),
    .S_AXIS_TLAST(tlast),
    .USR_tcm_control(ctrl),
    .USR_rd_en(rd_en),
    .USR_rd_valid(rd_valid),
    .USR_rd_data(rd_data),
    .USR_rd_last(rd_last),
    .USR_level(level),
    .USR_pkt_count(pkt_count),
    .USR_full(full),
    .USR_empty(empty),
    .USR_pkt_done(pkt_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] strb_mask(input logic [DW-1:0] d, input logic [3:0] s);
    logic [DW-1:0] r;
    r = d;
`ifdef TCM_AXIS_SINK_STRB_EN
    for (int b = 0; b < 4; b++) if (!s[b]) r[8*b +: 8] = 8'h00;
`endif
    return r;
  endfunction

  function automatic int model_pkts();
    int n;
    n = 0;
    foreach (q[i]) if (q[i].last) n++;
    return n;
  endfunction

  // Reference model: a queue of stored beats, updated from the inputs at each edge.
  always @(posedge clk) begin : m_upd
    bit push;
    bit pop;
    if (!aresetn) begin
      q.delete();
      exp_pd = 1'b0;
    end else begin
      push   = tvalid && ctrl[1] && !ctrl[0] && (q.size() < D);
      pop    = rd_en && (q.size() != 0);
      exp_pd = push && tlast;
      if (ctrl[0]) begin
        q.delete();
      end else begin
        if (pop)  void'(q.pop_front());
        if (push) q.push_back('{last: tlast, data: strb_mask(tdata, tstrb)});
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("tready",    tready,    aresetn && ctrl[1] && !ctrl[0] && (q.size() < D));
      chk("level",     level,     q.size());
      chk("pkt_count", pkt_count, model_pkts());
      chk("full",      full,      q.size() == D);
      chk("empty",     empty,     q.size() == 0);
      chk("rd_valid",  rd_valid,  q.size() != 0);
      chk("rd_data",   rd_data,   (q.size() != 0) ? q[0].data : '0);
      chk("rd_last",   rd_last,   (q.size() != 0) ? q[0].last : 1'b0);
      chk("pkt_done",  pkt_done,  exp_pd);
      if (pkt_done) pd_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_drain();
    pd_cnt = 0;
    for (int i = 1; i <= 16; i++) begin
      tvalid = 1'b1;
      tdata  = DW'(i);
      tlast  = (i == 16);
      tick();
    end
    tdata = 32'h11;
    tlast = 1'b0;
    repeat (3) tick();
    chk("fill_full",   full,      1);
    chk("fill_tready", tready,    0);
    chk("fill_pkts",   pkt_count, 1);
    chk("fill_level",  level,     16);
    chk("fill_pdone",  pd_cnt,    1);
    tvalid = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      chk("drain_data", rd_data, DW'(i));
      chk("drain_last", rd_last, (i == 16));
      rd_en = 1'b1;
      tick();
    end
    rd_en = 1'b0;
    chk("drain_empty", empty, 1);
    chk("drain_level", level, 0);
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    pd_cnt  = 0;
    cmp_en  = 1'b0;
    aresetn = 1'b0;
    tvalid  = 1'b0;
    tdata   = '0;
    tstrb   = 4'hF;
    tlast   = 1'b0;
    ctrl    = 32'h0;
    rd_en   = 1'b0;
    tick();
    cmp_en = 1'b1;
    tick();
    chk("rst_tready",  tready,   0);
    chk("rst_empty",   empty,    1);
    chk("rst_rd_data", rd_data,  0);
    chk("rst_pdone",   pkt_done, 0);

    aresetn = 1'b1;
    ctrl    = 32'h2;
    tick();
    chk("idle_tready",   tready,   1);
    chk("idle_empty",    empty,    1);
    chk("idle_level",    level,    0);
    chk("idle_rd_valid", rd_valid, 0);

    repeat (3) fill_drain();

    // Steady push+pop at level 5 moves both pointers through several wraps.
    tvalid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tdata = 32'h100 + DW'(k);
      tlast = (k % 4 == 3);
      tick();
    end
    rd_en = 1'b1;
    for (int k = 5; k < 45; k++) begin
      tdata = 32'h100 + DW'(k);
      tlast = (k % 4 == 3);
      tick();
      chk("stream_level", level, 5);
    end
    rd_en = 1'b0;

    tlast = 1'b1;
    tdata = 32'h200;
    tick();
    tdata = 32'h201;
    tick();
    chk("pre_flush_level", level, 7);
    ctrl  = 32'h3;
    tdata = 32'h2FF;
    tick();
    ctrl   = 32'h2;
    tvalid = 1'b0;
    chk("flush_level", level,     0);
    chk("flush_pkts",  pkt_count, 0);
    tick();
    chk("flush_empty", empty, 1);

    tvalid = 1'b1;
    tdata  = 32'hAABBCCDD;
    tstrb  = 4'b0101;
    tlast  = 1'b1;
    tick();
    tvalid = 1'b0;
    tstrb  = 4'hF;
`ifdef TCM_AXIS_SINK_STRB_EN
    chk("strb_data", rd_data, 32'h00BB00DD);
`else
    chk("strb_data", rd_data, 32'hAABBCCDD);
`endif
    chk("strb_last", rd_last, 1);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    chk("strb_empty", empty, 1);

    tvalid = 1'b1;
    tlast  = 1'b0;
    tdata  = 32'h300;
    tick();
    tdata = 32'h301;
    tick();
    ctrl  = 32'h0;
    tdata = 32'h302;
    #1;
    chk("dis_tready", tready, 0);
    tick();
    chk("dis_level", level, 2);
    rd_en = 1'b1;
    repeat (3) tick();
    rd_en  = 1'b0;
    tvalid = 1'b0;
    chk("dis_drained", level, 0);
    chk("dis_empty",   empty, 1);

    ctrl   = 32'h2;
    tvalid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tdata = 32'h400 + DW'(k);
      tick();
    end
    tvalid  = 1'b0;
    aresetn = 1'b0;
    tick();
    chk("mid_rst_empty", empty,   1);
    chk("mid_rst_level", level,   0);
    chk("mid_rst_data",  rd_data, 0);
    aresetn = 1'b1;
    tick();
    chk("post_rst_tready", tready, 1);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/tcm_axis_sink_fifo.md
# tcm_axis_sink_fifo

Parametrised AXI-Stream sink for the TCM datapath. It accepts stream beats into a circular buffer of configurable width and depth, preserves TLAST packet framing, and presents a first-word-fall-through read port to user logic. It supersedes the fixed 8-word, write-only sink: this block adds buffer drain, wrap-around, occupancy and packet counts, flush/enable control, and optional byte-strobe masking.

## Interface
Parameters:
- C_S_AXIS_TDATA_WIDTH, 32, stream data width; multiple of 8.
- C_FIFO_DEPTH, 16, buffer depth in beats; power of 2, ≥2. AW = clog2(C_FIFO_DEPTH).

Ports (one clock; reset is synchronous and active-low):
- S_AXIS_ACLK  in  1  clock; all logic on rising edge.
- S_AXIS_ARESETN  in  1  synchronous active-low reset.
- S_AXIS_TVALID  in  1  beat valid.
- S_AXIS_TREADY  out  1  sink ready.
- S_AXIS_TDATA  in  C_S_AXIS_TDATA_WIDTH  beat data.
- S_AXIS_TSTRB  in  C_S_AXIS_TDATA_WIDTH/8  byte strobes.
- S_AXIS_TLAST  in  1  last beat of packet.
- USR_tcm_control  in  32  bit0 = flush, bit1 = sink enable; bits 31:2 reserved, ignored.
- USR_rd_en  in  1  pop request.
- USR_rd_valid  out  1  head entry valid (= !USR_empty).
- USR_rd_data  out  C_S_AXIS_TDATA_WIDTH  head entry data.
- USR_rd_last  out  1  head entry TLAST flag.
- USR_level  out  AW+1  entries stored, 0..C_FIFO_DEPTH.
- USR_pkt_count  out  AW+1  complete packets (TLAST beats) stored.
- USR_full  out  1  level == C_FIFO_DEPTH.
- USR_empty  out  1  level == 0.
- USR_pkt_done  out  1  one-cycle pulse, cycle after a TLAST beat is accepted.

## Operation
- Storage: C_FIFO_DEPTH × (data + last bit); write pointer wp, read pointer rp, each AW bits, wrap modulo depth; level counter AW+1 bits.
- S_AXIS_TREADY = enable && !flush && !USR_full, derived from registered state only (no combinational path from USR_rd_en or TVALID).
- Push = TVALID && TREADY: write {TLAST, TDATA} at wp, wp+1.
- Pop = USR_rd_en && USR_rd_valid: rp+1. USR_rd_en while empty is ignored; no underflow.
- Level: +1 on push only, −1 on pop only, unchanged on both.
- USR_pkt_count: +1 when pushed beat has TLAST, −1 when popped head has last=1, unchanged if both.
- Flush (bit0=1): synchronous clear of wp, rp, level, pkt_count; flush has priority over same-cycle push and pop; memory contents not cleared.
- Enable (bit1=0): TREADY low; read side continues draining.
- No state machine beyond pointers/counters; TVALID without TREADY leaves all state unchanged.

## Timing
- Reset (ARESETN=0 at edge): wp=rp=0, level=0, pkt_count=0; outputs TREADY=0, USR_rd_valid=0, USR_rd_last=0, USR_rd_data=0 (masked while empty), USR_level=0, USR_pkt_count=0, USR_full=0, USR_empty=1, USR_pkt_done=0. Reset mid-packet discards all stored data.
- Write-to-read latency: beat pushed at edge N appears on USR_rd_* after edge N (visible in cycle N+1); no same-cycle pass-through when empty.
- Read: FWFT; USR_rd_data/USR_rd_last valid combinationally whenever USR_rd_valid=1; new head visible the cycle after a pop.
- Full: pop at full raises TREADY in the next cycle; no push in the popping cycle.
- Wrap: wp/rp roll from C_FIFO_DEPTH−1 to 0 with no bubble.

## Configuration
- TCM_AXIS_SINK_STRB_EN defined: byte i of stored data = TDATA byte i if TSTRB[i]=1, else 8'h00.
- Undefined: TSTRB ignored; full TDATA stored unmodified.

## Test plan
- Reset, enable=1, no traffic -> TREADY=1, USR_empty=1, USR_level=0, USR_rd_valid=0.
- Push 16 beats 0x00000001..0x00000010 (depth 16), TLAST on 16th -> USR_full=1, TREADY=0, USR_pkt_count=1, USR_pkt_done pulse once; 17th beat held off.
- Then pop 16 -> data 0x1..0x10 in order, USR_rd_last=1 only on 0x10, USR_empty=1; repeat 3 fills to cover pointer wrap.
- Continuous push+pop at level 5 for 40 cycles -> USR_level stays 5, data order preserved.
- Flush with level 7 and simultaneous push -> next cycle level=0, pkt_count=0, pushed beat discarded.
- TSTRB=4'b0101, TDATA=0xAABBCCDD -> with TCM_AXIS_SINK_STRB_EN read 0x00BB00DD; without, 0xAABBCCDD.
